shift_reg_controller: RTL and testbench
=======================================

Name: shift_reg_controller

Overview:
- Command sequencer for the 8-bit shifter with parallel load, made of a Mux4_1 array and DFlipFlop array.
- Accepts one command at a time over a valid/ready handshake: parallel load, N-step shift left, N-step shift right, or N-step rotate left.
- Drives the shifter's select1/select2, dataR/dataL and parallel data inputs cycle by cycle, then pulses done.
- Sits between a host/bus-side requester and one shifter instance; shifter Q is fed back for rotate.

Parameters:
- BUS_WIDTH, 8, shifter width in bits; must match the shifter instance.
- CNT_W, 4, width of the shift-count field; max shifts per command = 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock, shared with the shifter
- rst_n  input  1  asynchronous active-low reset
- cmd_valid_i  input  1  command present
- cmd_ready_o  output  1  controller can accept a command (IDLE only)
- cmd_op_i  input  2  00 LOAD, 01 SHL (fill at LSB), 10 SHR (fill at MSB), 11 ROL
- cmd_count_i  input  CNT_W  number of shift steps (ignored for LOAD)
- cmd_data_i  input  BUS_WIDTH  parallel load value (LOAD only)
- cmd_fill_i  input  1  serial fill bit for SHL/SHR
- shifter_q_i  input  BUS_WIDTH  shifter Q outputs
- select1_o  output  1  to shifter select1_i (mode code bit 0)
- select2_o  output  1  to shifter select2_i (mode code bit 1)
- dataR_o  output  1  to shifter dataR_i (enters bit 0 on SHL/ROL)
- dataL_o  output  1  to shifter dataL_i (enters MSB on SHR)
- load_data_o  output  BUS_WIDTH  to shifter data_i
- busy_o  output  1  command in progress
- done_o  output  1  one-cycle pulse when a command completes

Behaviour:
- Mode code {select2_o,select1_o}:
  - 00 hold
  - 01 parallel load
  - 10 shift toward MSB; dataR_o enters bit 0
  - 11 shift toward LSB; dataL_o enters MSB
- Reset (async assert, sync release):
  - state IDLE; cmd_ready_o=1; all other outputs 0; mode 00.
  - Internal op/count/data/fill registers cleared.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cmd_ready_o=1, mode 00.
  - On clk edge with cmd_valid_i=1, latch op, count, data and fill.
  - Next state: LOAD if op=00; DONE if op≠00 and count=0; else SHIFT.
  - cmd_valid_i=0 stays in IDLE.
- LOAD:
  - One cycle; mode 01; load_data_o = latched data.
  - Shifter captures it at the next edge; next state DONE.
- SHIFT:
  - Mode 10 for SHL/ROL, 11 for SHR.
  - dataR_o = fill (SHL) or shifter_q_i[BUS_WIDTH-1] (ROL); dataL_o = fill (SHR).
  - Remaining-count register decrements each edge; on the edge where remaining=1, next state DONE.
  - Exactly count shift edges occur.
- DONE: mode 00; done_o=1 for exactly one cycle; next state IDLE.
- Outputs are decoded only from registered state/op/fill, never combinationally from cmd_*_i.
  - shifter_q_i is the sole combinational input path, ROL only.
  - dataR_o/dataL_o/load_data_o are 0 when not used by the current state.
- Latency from accept edge:
  - LOAD: done_o high during cycle 2, ready again at cycle 3.
  - Shift with count=N≥1: done_o high during cycle N+1, ready again at cycle N+2.
  - count=0: done_o in cycle 1, shifter untouched.
- busy_o = (state≠IDLE); cmd_ready_o = ~busy_o.
- cmd_valid_i while busy: not accepted; requester must hold it; it is accepted on the first IDLE edge.
- Back-to-back: a command held valid through DONE is accepted on the first IDLE edge; no bubble other than the IDLE cycle.
- Reset asserted mid-command: immediate return to IDLE, mode 00.
  - The shifter keeps its partially shifted contents, since it has no reset.
  - No done_o is produced for the aborted command.
- Count wraps: no; the max count 2^CNT_W-1 is honoured exactly.

Optional Feature:
- Macro: SHIFT_REG_CONTROLLER_SEROUT_EN
- Defined: adds ports ser_o (1) and ser_valid_o (1).
  - During each SHIFT cycle, ser_valid_o=1 and ser_o = the bit about to leave: shifter_q_i[BUS_WIDTH-1] for SHL/ROL, shifter_q_i[0] for SHR.
  - Both are 0 otherwise and on reset.
- Undefined: ports absent; no other behaviour change.

Test Plan:
- Reset, then LOAD data=0xA5 → mode 01 for one cycle; shifter Q=0xA5; done_o pulse; cmd_ready_o back high 3 cycles after accept.
- Q=0x81, SHL count=3, fill=1 → mode 10 for exactly 3 cycles; Q=0x0F; done_o one cycle.
- Q=0x81, SHR count=2, fill=0 → mode 11 for 2 cycles; Q=0x20.
- Q=0x96, ROL count=8 → Q returns to 0x96. With SERout_EN, ser_o sequence is 1,0,0,1,0,1,1,0.
- SHL count=0 → no shift cycles, Q unchanged, done_o in the cycle after accept. A second command held valid while busy is accepted only after IDLE is re-entered.
- rst_n pulsed low mid-SHIFT (count=10, after 4 steps) → outputs 0 and IDLE immediately, no done_o, Q holds 4-step value. A subsequent LOAD 0x3C works normally.

Source files
------------

// File: rtl/shift_reg_controller.sv
// Command sequencer for the 8-bit Mux4_1/DFlipFlop shifter: LOAD, SHL, SHR and ROL over valid/ready.
// Optional serial-out tap (ser_o/ser_valid_o) enabled by defining SHIFT_REG_CONTROLLER_SEROUT_EN.
module shift_reg_controller #(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [CNT_W-1:0]     cmd_count_i,
    input  logic [BUS_WIDTH-1:0] cmd_data_i,
    input  logic                 cmd_fill_i,
    input  logic [BUS_WIDTH-1:0] shifter_q_i,
    output logic                 select1_o,
    output logic                 select2_o,
    output logic                 dataR_o,
    output logic                 dataL_o,
    output logic [BUS_WIDTH-1:0] load_data_o,
    output logic                 busy_o,
`ifdef SHIFT_REG_CONTROLLER_SEROUT_EN
    output logic                 ser_o,
    output logic                 ser_valid_o,
`endif
    output logic                 done_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SHL    = 2'b01;
    localparam logic [1:0] OP_SHR    = 2'b10;
    localparam logic [1:0] OP_ROL    = 2'b11;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DOWN = 2'b11;

    state_t                 r_state;
    logic [1:0]             r_op;
    logic [CNT_W-1:0]       r_cnt;
    logic [BUS_WIDTH-1:0]   r_data;
    logic                   r_fill;
    logic [1:0]             r_sel;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_shift;
    logic                   w_unused_q;

    // Sequencer: r_cnt holds the shift steps still to go while in S_SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_cnt   <= '0;
            r_data  <= '0;
            r_fill  <= 1'b0;
            r_sel   <= MODE_HOLD;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_op   <= cmd_op_i;
                        r_cnt  <= cmd_count_i;
                        r_data <= cmd_data_i;
                        r_fill <= cmd_fill_i;
                        r_busy <= 1'b1;
                        if (cmd_op_i == OP_LOAD) begin
                            r_state <= S_LOAD;
                            r_sel   <= MODE_LOAD;
                        end else if (cmd_count_i == CNT_W'(0)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                            r_sel   <= (cmd_op_i == OP_SHR) ? MODE_DOWN : MODE_UP;
                        end
                    end
                end
                S_LOAD: begin
                    r_state <= S_DONE;
                    r_sel   <= MODE_HOLD;
                    r_done  <= 1'b1;
                end
                S_SHIFT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_sel   <= MODE_HOLD;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Serial data lines are forced low outside the states that use them; ROL feeds back the MSB.
    assign w_shift     = (r_state == S_SHIFT);
    assign dataR_o     = w_shift & (((r_op == OP_SHL) & r_fill) |
                                    ((r_op == OP_ROL) & shifter_q_i[BUS_WIDTH-1]));
    assign dataL_o     = w_shift & (r_op == OP_SHR) & r_fill;
    assign load_data_o = (r_state == S_LOAD) ? r_data : '0;
    assign select1_o   = r_sel[0];
    assign select2_o   = r_sel[1];
    assign busy_o      = r_busy;
    assign cmd_ready_o = ~r_busy;
    assign done_o      = r_done;
    assign w_unused_q  = ^shifter_q_i;

`ifdef SHIFT_REG_CONTROLLER_SEROUT_EN
    assign ser_valid_o = w_shift;
    assign ser_o       = w_shift & ((r_op == OP_SHR) ? shifter_q_i[0] : shifter_q_i[BUS_WIDTH-1]);
`endif

endmodule

// File: tb/tb_shift_reg_controller.sv
// Bench for shift_reg_controller: behavioural shifter plus arithmetic reference for expected Q and per-cycle outputs.
module tb_shift_reg_controller;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i;
    logic [CW-1:0] cmd_count_i;
    logic [W-1:0]  cmd_data_i;
    logic          cmd_fill_i;
    logic [W-1:0]  sh_q = '0;
    logic          select1_o;
    logic          select2_o;
    logic          dataR_o;
    logic          dataL_o;
    logic [W-1:0]  load_data_o;
    logic          busy_o;
    logic          done_o;
`ifdef SHIFT_REG_CONTROLLER_SEROUT_EN
    logic          ser_o;
    logic          ser_valid_o;
`endif

    int            total = 0;
    int            bad   = 0;
    string         g_step = "init";
    logic [W-1:0]  m_q;

    always #5 clk = ~clk;

    shift_reg_controller #(.BUS_WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_count_i (cmd_count_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_fill_i  (cmd_fill_i),
        .shifter_q_i (sh_q),
        .select1_o   (select1_o),
        .select2_o   (select2_o),
        .dataR_o     (dataR_o),
        .dataL_o     (dataL_o),
        .load_data_o (load_data_o),
        .busy_o      (busy_o),
`ifdef SHIFT_REG_CONTROLLER_SEROUT_EN
        .ser_o       (ser_o),
        .ser_valid_o (ser_valid_o),
`endif
        .done_o      (done_o)
    );

    // The shifter itself: no reset, mode {select2,select1}.
    always_ff @(posedge clk) begin
        case ({select2_o, select1_o})
            2'b01:   sh_q <= load_data_o;
            2'b10:   sh_q <= {sh_q[W-2:0], dataR_o};
            2'b11:   sh_q <= {dataL_o, sh_q[W-1:1]};
            default: sh_q <= sh_q;
        endcase
    end

    // Expected register contents after k steps of a command, from plain arithmetic.
    function automatic logic [W-1:0] apply(input int unsigned op, input logic [W-1:0] q,
                                           input int unsigned k, input logic fill,
                                           input logic [W-1:0] data);
        int unsigned v, n, r, f, full;
        v    = 32'(q);
        n    = (k > W) ? W : k;
        f    = fill ? 32'hFFFF_FFFF : 32'h0;
        full = (32'd1 << W) - 32'd1;
        case (op)
            0:       return (k > 0) ? data : q;
            1:       return W'((v << n) | (f & ((32'd1 << n) - 32'd1)));
            2:       return W'((v >> n) | (f & full & ~((32'd1 << (W - n)) - 32'd1)));
            default: begin
                r = k % W;
                return W'((v << r) | (v >> (W - r)));
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", g_step, tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(cmd_ready_o), 32'd1);
        chk({tag, "_busy"},  32'(busy_o), 32'd0);
        chk({tag, "_done"},  32'(done_o), 32'd0);
        chk({tag, "_mode"},  32'({select2_o, select1_o}), 32'd0);
        chk({tag, "_lines"}, 32'({dataR_o, dataL_o, load_data_o}), 32'd0);
    endtask

    // Issue one command from an IDLE cycle (#1 after an edge) and check every cycle until IDLE again.
    task automatic run_cmd(input int unsigned op, input int unsigned cnt,
                           input logic [W-1:0] data, input logic fill);
        logic [W-1:0]  q0, cur;
        int unsigned   nwork;
        logic [1:0]    exp_mode;
        chk("pre_ready", 32'(cmd_ready_o), 32'd1);
        cmd_op_i    = 2'(op);
        cmd_count_i = CW'(cnt);
        cmd_data_i  = data;
        cmd_fill_i  = fill;
        cmd_valid_i = 1'b1;
        q0          = m_q;
        nwork       = (op == 0) ? 1 : cnt;
        exp_mode    = (op == 0) ? 2'b01 : (op == 2) ? 2'b11 : 2'b10;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        for (int unsigned k = 1; k <= nwork; k++) begin
            cur = apply(op, q0, k - 1, fill, data);
            chk("mode",  32'({select2_o, select1_o}), 32'(exp_mode));
            chk("busy",  32'(busy_o), 32'd1);
            chk("ready", 32'(cmd_ready_o), 32'd0);
            chk("done",  32'(done_o), 32'd0);
            chk("load",  32'(load_data_o), 32'((op == 0) ? data : '0));
            chk("dataR", 32'(dataR_o), 32'((op == 1) ? fill : (op == 3) ? cur[W-1] : 1'b0));
            chk("dataL", 32'(dataL_o), 32'((op == 2) ? fill : 1'b0));
            chk("q_mid", 32'(sh_q), 32'(cur));
`ifdef SHIFT_REG_CONTROLLER_SEROUT_EN
            chk("ser_valid", 32'(ser_valid_o), 32'(op != 0));
            chk("ser_o", 32'(ser_o), 32'((op == 0) ? 1'b0 : (op == 2) ? cur[0] : cur[W-1]));
`endif
            @(posedge clk); #1;
        end
        m_q = apply(op, q0, nwork, fill, data);
        chk("done_pulse", 32'(done_o), 32'd1);
        chk("done_mode",  32'({select2_o, select1_o}), 32'd0);
        chk("done_busy",  32'(busy_o), 32'd1);
        chk("q_final",    32'(sh_q), 32'(m_q));
        @(posedge clk); #1;
        chk_idle("after");
    endtask

    initial begin
        logic [W-1:0] q_abort;
        rst_n       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'b00;
        cmd_count_i = '0;
        cmd_data_i  = '0;
        cmd_fill_i  = 1'b0;
        m_q         = '0;
        #3;
        g_step = "reset";
        chk_idle("rst");
`ifdef SHIFT_REG_CONTROLLER_SEROUT_EN
        chk("rst_ser", 32'({ser_o, ser_valid_o}), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        g_step = "load_a5";   run_cmd(0, 0, 8'hA5, 1'b0);
        g_step = "load_81";   run_cmd(0, 0, 8'h81, 1'b0);
        g_step = "shl3";      run_cmd(1, 3, 8'h00, 1'b1);
        chk("shl3_q", 32'(sh_q), 32'h0F);
        g_step = "load_81b";  run_cmd(0, 0, 8'h81, 1'b0);
        g_step = "shr2";      run_cmd(2, 2, 8'h00, 1'b0);
        chk("shr2_q", 32'(sh_q), 32'h20);
        g_step = "load_96";   run_cmd(0, 0, 8'h96, 1'b0);
        g_step = "rol8";      run_cmd(3, 8, 8'h00, 1'b0);
        chk("rol8_q", 32'(sh_q), 32'h96);

        // Zero-count shift with the next command held valid while busy.
        g_step = "shl0_b2b";
        cmd_op_i = 2'b01; cmd_count_i = '0; cmd_fill_i = 1'b1; cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        cmd_op_i = 2'b00; cmd_data_i = 8'h55;
        chk("zero_done",  32'(done_o), 32'd1);
        chk("zero_ready", 32'(cmd_ready_o), 32'd0);
        chk("zero_q",     32'(sh_q), 32'(m_q));
        @(posedge clk); #1;
        chk_idle("held");
        chk("held_q", 32'(sh_q), 32'(m_q));
        g_step = "b2b_load55"; run_cmd(0, 0, 8'h55, 1'b0);

        g_step = "shr15";     run_cmd(2, 15, 8'h00, 1'b1);

        // Reset in the middle of a 10-step shift, after 4 steps.
        g_step = "abort";
        run_cmd(0, 0, 8'hC3, 1'b0);
        cmd_op_i = 2'b01; cmd_count_i = CW'(10); cmd_fill_i = 1'b1; cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        q_abort = apply(1, m_q, 4, 1'b1, '0);
        rst_n = 1'b0;
        #1;
        chk_idle("abort");
        chk("abort_q", 32'(sh_q), 32'(q_abort));
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_idle("abort_hold");
        chk("abort_hold_q", 32'(sh_q), 32'(q_abort));
        @(posedge clk); #1;
        chk_idle("abort_rel");
        chk("abort_rel_q", 32'(sh_q), 32'(q_abort));
        m_q = q_abort;
        g_step = "load_3c";   run_cmd(0, 0, 8'h3C, 1'b0);

        for (int i = 0; i < 24; i++) begin
            int unsigned r_op, r_cnt;
            r_op  = $urandom_range(0, 3);
            r_cnt = (i % 6 == 0) ? 15 : $urandom_range(0, 15);
            g_step = $sformatf("rand%0d_op%0d_n%0d", i, r_op, r_cnt);
            run_cmd(r_op, r_cnt, W'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
